// File: rtl/board_pkg.sv
// board_pkg: piece codes, ASCII constants, frame geometry and FSM states
// shared by the board rendering blocks.
package board_pkg;
    localparam logic [3:0] EMPTY    = 4'd0;
    localparam logic [3:0] W_PAWN   = 4'd1;
    localparam logic [3:0] W_KNIGHT = 4'd2;
    localparam logic [3:0] W_BISHOP = 4'd3;
    localparam logic [3:0] W_ROOK   = 4'd4;
    localparam logic [3:0] W_QUEEN  = 4'd5;
    localparam logic [3:0] W_KING   = 4'd6;
    localparam logic [3:0] B_PAWN   = 4'd9;
    localparam logic [3:0] B_KNIGHT = 4'd10;
    localparam logic [3:0] B_BISHOP = 4'd11;
    localparam logic [3:0] B_ROOK   = 4'd12;
    localparam logic [3:0] B_QUEEN  = 4'd13;
    localparam logic [3:0] B_KING   = 4'd14;

    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_ESC     = 8'h1B;
    localparam logic [7:0] CH_LBRACK  = 8'h5B;
    localparam logic [7:0] CH_HOME    = 8'h48;
    localparam logic [7:0] CH_CURSOR  = 8'h40;
    localparam logic [7:0] CH_EMPTY   = 8'h2E;
    localparam logic [7:0] CH_UNKNOWN = 8'h3F;

    localparam int FRAME_LEN_HOME  = 83;
    localparam int FRAME_LEN_PLAIN = 80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_READ,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } tx_state_t;
endpackage

// File: rtl/board_tx_sequencer_piece_to_ascii.sv
// piece_to_ascii: maps a 4-bit piece code to its board character, with the
// cursor glyph taking precedence when the overlay is active.
module piece_to_ascii
    import board_pkg::*;
(
    input  logic [3:0] code,
    input  logic       overlay,
    output logic [7:0] ch
);
    logic [7:0] base;

    always_comb begin
        case (code)
            EMPTY:    base = CH_EMPTY;
            W_PAWN:   base = "P";
            W_KNIGHT: base = "N";
            W_BISHOP: base = "B";
            W_ROOK:   base = "R";
            W_QUEEN:  base = "Q";
            W_KING:   base = "K";
            B_PAWN:   base = "p";
            B_KNIGHT: base = "n";
            B_BISHOP: base = "b";
            B_ROOK:   base = "r";
            B_QUEEN:  base = "q";
            B_KING:   base = "k";
            default:  base = CH_UNKNOWN;
        endcase
        ch = overlay ? CH_CURSOR : base;
    end
endmodule

// File: rtl/board_tx_sequencer.sv
// board_tx_sequencer: streams the 8x8 board as ASCII text through a byte UART,
// with optional cursor-home prefix and a blinking cursor overlay.
module board_tx_sequencer
    import board_pkg::*;
#(
    parameter int BLINK_DIV    = 26,
    parameter int HOME_EN      = 1,
    parameter int AUTO_REFRESH = 1,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] cursor_pos,
    input  logic       cursor_en,
    output logic [5:0] board_addr,
    input  logic [3:0] board_piece,
    output logic [7:0] tx_data,
    output logic       tx_stb,
    input  logic       tx_busy,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       blink
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    tx_state_t state, nxt;
    logic [BLINK_DIV-1:0] div;
    logic [TW-1:0] tcnt;
    logic [2:0] rank;
    logic [3:0] col;
    logic [1:0] hcnt;
    logic hdr, pend, blink_f;
    logic tgl, req, is_sq, last, adv, done, launch;
    logic [7:0] const_ch, sq_ch;

    assign tgl        = &div;
    assign req        = start | ((AUTO_REFRESH != 0) & tgl);
    assign is_sq      = !hdr && !col[3];
    assign last       = !hdr && rank == 3'd7 && col == 4'd9;
    assign const_ch   = hdr ? (hcnt == 2'd0 ? CH_ESC : hcnt == 2'd1 ? CH_LBRACK : CH_HOME)
                            : (col == 4'd8 ? CH_LF : CH_CR);
    assign board_addr = {rank, col[2:0]};
    assign tx_stb     = state == S_STROBE && !tx_busy;
    // A missing ack is treated like a completed byte so a dead UART cannot hang the frame
    assign adv        = !tx_busy && (state == S_WAIT_DONE || (state == S_WAIT_ACK && tcnt == T_LAST));
    assign done       = adv && last;
    assign launch     = (req && state == S_IDLE) || (done && (pend || req));
    assign frame_done = done;

    piece_to_ascii u_map (
        .code   (board_piece),
        .overlay(cursor_en && blink_f && board_addr == cursor_pos),
        .ch     (sq_ch)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:      nxt = req ? S_PREP : S_IDLE;
            S_PREP:      nxt = is_sq ? S_READ : S_STROBE;
            S_READ:      nxt = S_STROBE;
            S_STROBE:    nxt = tx_busy ? S_STROBE : S_WAIT_ACK;
            S_WAIT_ACK:  nxt = tx_busy ? S_WAIT_DONE : adv ? S_PREP : S_WAIT_ACK;
            S_WAIT_DONE: nxt = adv ? S_PREP : S_WAIT_DONE;
            default:     nxt = S_IDLE;
        endcase
        if (done && !launch) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            div        <= '0;
            blink      <= 1'b0;
            blink_f    <= 1'b0;
            tcnt       <= '0;
            pend       <= 1'b0;
            frame_busy <= 1'b0;
            hdr        <= 1'b0;
            hcnt       <= '0;
            rank       <= '0;
            col        <= '0;
            tx_data    <= '0;
        end else begin
            state <= nxt;
            div   <= div + 1'b1;
            if (tgl) blink <= ~blink;
            tcnt <= state == S_WAIT_ACK ? tcnt + 1'b1 : '0;
            pend <= !done && (pend || (req && frame_busy));
            if (launch) begin
                frame_busy <= 1'b1;
                hdr        <= (HOME_EN != 0);
                hcnt       <= '0;
                rank       <= '0;
                col        <= '0;
                blink_f    <= blink ^ tgl;
            end else if (done) begin
                frame_busy <= 1'b0;
                rank       <= '0;
                col        <= '0;
            end else if (adv) begin
                if (hdr) begin
                    hcnt <= hcnt + 1'b1;
                    hdr  <= hcnt != 2'd2;
                end else if (col == 4'd9) begin
                    col  <= '0;
                    rank <= rank + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == S_PREP && !is_sq) tx_data <= const_ch;
            if (state == S_READ) tx_data <= sq_ch;
        end
    end
endmodule

// File: tb/tb_board_tx_sequencer.sv
// tb_board_tx_sequencer: directed scenarios against a board-store model and a
// UART busy model, comparing captured bytes with a reference frame builder.
module tb_board_tx_sequencer;
    logic       clk = 0, rst = 0, start = 0, cursor_en = 0;
    logic [5:0] cursor_pos = 0, board_addr;
    logic [3:0] board_piece = 0;
    logic [7:0] tx_data;
    logic       tx_stb, tx_busy, frame_busy, frame_done, blink;
    int  total = 0, bad = 0, done_cnt = 0, fb_falls = 0, cyc = 0, bcnt = 0;
    bit  never = 0, fb_prev = 0, ok;
    logic [3:0] mem [64];
    logic [7:0] cap [$];
    int  stb_t [$];
    string pmap = ".PNBRQK??pnbrqk?";

    board_tx_sequencer #(.BLINK_DIV(12), .HOME_EN(1), .AUTO_REFRESH(1), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .cursor_pos(cursor_pos), .cursor_en(cursor_en),
        .board_addr(board_addr), .board_piece(board_piece), .tx_data(tx_data), .tx_stb(tx_stb),
        .tx_busy(tx_busy), .frame_busy(frame_busy), .frame_done(frame_done), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;

    always @(posedge clk) board_piece <= mem[board_addr];

    always @(posedge clk or negedge rst)
        if (!rst) bcnt <= 0;
        else if (tx_stb && !never) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    assign tx_busy = bcnt != 0;

    always @(negedge clk) begin
        if (rst) begin
            if (tx_stb) begin
                cap.push_back(tx_data);
                stb_t.push_back(cyc);
                total++;
                if (tx_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL stb_while_busy got busy=%b exp=0 at cyc %0d", tx_busy, cyc);
                end
            end
            if (frame_done) done_cnt++;
            if (fb_prev && !frame_busy) fb_falls++;
            fb_prev = frame_busy;
        end
    end

    function automatic logic [7:0] exp_byte(int i, bit ovl);
        int p, r, c, sq;
        if (i < 3) return i == 0 ? 8'h1B : i == 1 ? 8'h5B : 8'h48;
        p = i - 3;
        r = p / 10;
        c = p % 10;
        if (c == 8) return 8'h0A;
        if (c == 9) return 8'h0D;
        sq = r * 8 + c;
        if (ovl && sq == 36) return 8'h40;
        return pmap[int'(mem[sq])];
    endfunction

    task automatic do_reset;
        rst = 0;
        start = 0;
        repeat (3) @(negedge clk);
        cap.delete();
        stb_t.delete();
        done_cnt = 0;
        fb_falls = 0;
        fb_prev = 0;
        rst = 1;
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input int n, input int lim, output bit got);
        got = 0;
        for (int k = 0; k < lim && !got; k++) begin
            @(negedge clk);
            got = done_cnt >= n;
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(negedge clk);
        total++; if (tx_stb !== 1'b0)     begin bad++; $display("FAIL reset_tx_stb got=%b exp=0", tx_stb); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL reset_frame_busy got=%b exp=0", frame_busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (blink !== 1'b0)      begin bad++; $display("FAIL reset_blink got=%b exp=0", blink); end
        total++; if (board_addr !== 6'd0) begin bad++; $display("FAIL reset_board_addr got=%0d exp=0", board_addr); end
        rst = 1;
        repeat (50) @(negedge clk);
        total++; if (cap.size() != 0)     begin bad++; $display("FAIL idle_no_strobe got=%0d exp=0", cap.size()); end
    endtask

    task automatic test_full_frame;
        do_reset();
        pulse_start();
        wait_done(1, 3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL frame_timeout got done=%0d exp=1", done_cnt); end
        total++; if (cap.size() != 83) begin bad++; $display("FAIL frame_len got=%0d exp=83", cap.size()); end
        for (int i = 0; i < 83 && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_byte(i, 0)) begin
                bad++;
                $display("FAIL frame_byte[%0d] got=%h exp=%h", i, cap[i], exp_byte(i, 0));
            end
        end
        repeat (20) @(negedge clk);
        total++; if (done_cnt != 1)       begin bad++; $display("FAIL frame_done_count got=%0d exp=1", done_cnt); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL frame_busy_after got=%b exp=0", frame_busy); end
        total++; if (blink !== 1'b0)      begin bad++; $display("FAIL blink_early got=%b exp=0", blink); end
    endtask

    task automatic test_cursor_blink;
        do_reset();
        cursor_en = 1;
        cursor_pos = 36;
        while (cyc < 4100) @(negedge clk);
        total++; if (blink !== 1'b1)      begin bad++; $display("FAIL blink_on got=%b exp=1", blink); end
        total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL auto_refresh got=%b exp=1", frame_busy); end
        wait_done(1, 3000, ok);
        total++; if (cap.size() != 83)    begin bad++; $display("FAIL cur_len got=%0d exp=83", cap.size()); end
        total++; if (cap.size() > 47 && cap[47] !== 8'h40) begin bad++; $display("FAIL cursor_on got=%h exp=40", cap[47]); end
        for (int i = 0; i < 83 && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_byte(i, 1)) begin
                bad++;
                $display("FAIL cur_byte[%0d] got=%h exp=%h", i, cap[i], exp_byte(i, 1));
            end
        end
        wait_done(2, 6000, ok);
        total++; if (cap.size() != 166)   begin bad++; $display("FAIL cur_off_len got=%0d exp=166", cap.size()); end
        total++; if (cap.size() > 130 && cap[130] !== 8'h2E) begin bad++; $display("FAIL cursor_off got=%h exp=2e", cap[130]); end
        total++; if (blink !== 1'b0)      begin bad++; $display("FAIL blink_off got=%b exp=0", blink); end
        cursor_en = 0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        while (cyc < 3600) @(negedge clk);
        pulse_start();
        while (cyc < 3800) @(negedge clk);
        pulse_start();
        while (cyc < 4000) @(negedge clk);
        pulse_start();
        while (cyc < 4100) @(negedge clk);
        total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL b2b_mid_busy got=%b exp=1", frame_busy); end
        wait_done(2, 5000, ok);
        repeat (300) @(negedge clk);
        total++; if (done_cnt != 2)       begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt); end
        total++; if (fb_falls != 1)       begin bad++; $display("FAIL b2b_busy_drops got=%0d exp=1", fb_falls); end
        total++; if (cap.size() != 166)   begin bad++; $display("FAIL b2b_len got=%0d exp=166", cap.size()); end
        total++; if (cap.size() > 86 && cap[86] !== 8'h72) begin bad++; $display("FAIL b2b_second_frame got=%h exp=72", cap[86]); end
    endtask

    task automatic test_timeout;
        do_reset();
        never = 1;
        pulse_start();
        wait_done(1, 3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_hang got done=%0d exp=1", done_cnt); end
        total++; if (cap.size() != 83)    begin bad++; $display("FAIL to_len got=%0d exp=83", cap.size()); end
        total++; if ((stb_t.size() > 1 ? stb_t[1] - stb_t[0] : -1) != 17)
            begin bad++; $display("FAIL to_spacing got=%0d exp=17", stb_t.size() > 1 ? stb_t[1] - stb_t[0] : -1); end
        total++; if (cap.size() > 3 && cap[3] !== 8'h72) begin bad++; $display("FAIL to_byte3 got=%h exp=72", cap[3]); end
        never = 0;
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        pulse_start();
        for (int k = 0; k < 2000 && cap.size() < 36; k++) @(negedge clk);
        total++; if (cap.size() < 36)     begin bad++; $display("FAIL rm_reach_rank3 got=%0d exp=36", cap.size()); end
        #2 rst = 0;
        #1;
        total++; if (tx_stb !== 1'b0)     begin bad++; $display("FAIL rm_tx_stb got=%b exp=0", tx_stb); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rm_tx_data got=%h exp=00", tx_data); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL rm_frame_busy got=%b exp=0", frame_busy); end
        total++; if (board_addr !== 6'd0) begin bad++; $display("FAIL rm_board_addr got=%0d exp=0", board_addr); end
        repeat (2) @(negedge clk);
        n = cap.size();
        rst = 1;
        repeat (300) @(negedge clk);
        total++; if (cap.size() != n)     begin bad++; $display("FAIL rm_no_strobe got=%0d exp=%0d", cap.size(), n); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b exp=0", frame_busy); end
    endtask

    task automatic test_bad_code;
        mem[0] = 4'd7;
        do_reset();
        pulse_start();
        wait_done(1, 3000, ok);
        total++; if (cap.size() > 3 && cap[3] !== 8'h3F) begin bad++; $display("FAIL bad_code got=%h exp=3f", cap[3]); end
        total++; if (cap.size() > 4 && cap[4] !== 8'h6E) begin bad++; $display("FAIL bad_code_next got=%h exp=6e", cap[4]); end
        mem[0] = 4'd12;
    endtask

    initial begin
        int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int s = 0; s < 64; s++)
            mem[s] = s / 8 == 0 ? 4'(back[s % 8] + 8) : s / 8 == 1 ? 4'd9 :
                     s / 8 == 6 ? 4'd1 : s / 8 == 7 ? 4'(back[s % 8]) : 4'd0;
        test_reset();
        test_full_frame();
        test_cursor_blink();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_bad_code();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
